// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Latency: WIDTH+2 edges from acceptance to out_valid, including the acceptance edge; div-by-zero and overflow finish on the acceptance edge.
// Backpressure: in_ready only in IDLE; result held with out_valid until out_ready; flush aborts.
module muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, BUSY, FIN, DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_q, state_d;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   b_abs_q;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q;       // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic               neg_q;       // sign to apply to the selected result
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   result_q;

    // Request decode: operand signedness, magnitudes and special cases
    logic             a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             b_zero, ovf, fast, accept;
    logic [WIDTH-1:0] fast_res;

    assign a_signed = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    assign b_signed = op[2] ? ~op[0] : ~op[1];
    assign a_neg    = a_signed & a[WIDTH-1];
    assign b_neg    = b_signed & b[WIDTH-1];
    assign a_abs    = a_neg ? (~a + 1'b1) : a;
    assign b_abs    = b_neg ? (~b + 1'b1) : b;
    // Remainder follows the dividend sign; everything else takes the product/quotient sign
    assign neg_in   = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
    assign b_zero   = (b == '0);
    assign ovf      = op[2] & ~op[0] & (a == MIN_VAL) & (b == '1);
    assign fast     = op[2] & (b_zero | ovf);
    assign fast_res = b_zero ? (op[1] ? a : '1) : (op[1] ? '0 : MIN_VAL);

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign accept    = in_valid & in_ready & ~flush;

    // One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_abs_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_abs_q};
    assign div_next = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    // Sign correction and half/word selection applied in FIN
    logic [2*WIDTH-1:0] mul_full;
    logic [WIDTH-1:0]   quot_s, rem_s, fin_res;

    assign mul_full = neg_q ? (~acc_q + 1'b1) : acc_q;
    assign quot_s   = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    assign rem_s    = neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

    // Pick the architectural result for the latched op
    always_comb begin
        fin_res = '0;
        if (op_q[2])
            fin_res = op_q[1] ? rem_s : quot_s;
        else if (op_q[1:0] == 2'b00)
            fin_res = mul_full[WIDTH-1:0];
        else
            fin_res = mul_full[2*WIDTH-1:WIDTH];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; flush overrides every other transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = fast ? DONE : BUSY;
            BUSY: if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIN;
            FIN:  state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Datapath: latch operands on accept, iterate in BUSY, register result on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            b_abs_q  <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (!flush) begin
            case (state_q)
                IDLE: if (accept) begin
                    op_q    <= op;
                    b_abs_q <= b_abs;
                    neg_q   <= neg_in;
                    acc_q   <= {{WIDTH{1'b0}}, a_abs};
                    cnt_q   <= '0;
                    if (fast) result_q <= fast_res;
                end
                BUSY: begin
                    acc_q <= op_q[2] ? div_next : mul_next;
                    cnt_q <= cnt_q + 1'b1;
                end
                FIN:  result_q <= fin_res;
                default: ;
            endcase
        end
    end

endmodule
